// File: rtl/sc_comp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sc_comp_pkg                                            |
// | Description : Shared constants, opcode/funct codes and decode enums  |
// |               for the single-cycle MIPS-subset computer.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package sc_comp_pkg;

  localparam int XLEN      = 32;
  localparam int IM_DEPTH  = 128;
  localparam int DM_DEPTH  = 128;
  localparam int ADDR_BITS = 7;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_e;

  typedef enum logic [1:0] {
    NPC_PLUS4, NPC_BRANCH, NPC_JUMP, NPC_JREG
  } npc_sel_e;

  // Which instruction field names the destination register
  typedef enum logic [1:0] {
    DST_RD, DST_RT, DST_RA
  } dst_sel_e;

endpackage : sc_comp_pkg
`default_nettype wire

// File: rtl/sc_cpu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sc_cpu                                                 |
// | Description : Single-cycle MIPS-subset core: PC, decoder, ALU and    |
// |               register file. Unknown encodings retire as NOPs.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sc_cpu
  import sc_comp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [XLEN-1:0]      instr,
  output logic [XLEN-1:0]      PC,
  output logic [ADDR_BITS-1:0] dm_addr,
  output logic [XLEN-1:0]      dm_wdata,
  output logic                 dm_we,
  input  logic [XLEN-1:0]      dm_rdata,
  input  logic [4:0]           dbg_sel,
  output logic [XLEN-1:0]      dbg_data
);

  logic [5:0]      w_opcode, w_funct;
  logic [XLEN-1:0] w_rs_val, w_rt_val, w_imm_sext, w_imm_zext;
  logic [XLEN-1:0] w_src_b, w_alu_y, w_wb_data;
  logic [XLEN-1:0] w_pc_plus4, w_br_tgt, w_jmp_tgt, w_pc_next;
  logic [4:0]      w_wa;
  alu_op_e         w_alu_op;
  npc_sel_e        w_npc_sel;
  dst_sel_e        w_dst;
  logic            w_use_imm, w_imm_zx, w_reg_we, w_mem_we, w_mem_rd, w_br_ne, w_br_taken;

  assign w_opcode   = instr[31:26];
  assign w_funct    = instr[5:0];
  assign w_imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign w_imm_zext = {16'h0000, instr[15:0]};

  // Decode: every control defaults to a NOP so unlisted encodings change nothing but PC
  always_comb begin
    w_alu_op  = ALU_ADD;
    w_npc_sel = NPC_PLUS4;
    w_dst     = DST_RD;
    w_use_imm = 1'b0;
    w_imm_zx  = 1'b0;
    w_reg_we  = 1'b0;
    w_mem_we  = 1'b0;
    w_mem_rd  = 1'b0;
    w_br_ne   = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD:  begin w_alu_op = ALU_ADD; w_reg_we = 1'b1; end
          FN_SUB:  begin w_alu_op = ALU_SUB; w_reg_we = 1'b1; end
          FN_AND:  begin w_alu_op = ALU_AND; w_reg_we = 1'b1; end
          FN_OR:   begin w_alu_op = ALU_OR;  w_reg_we = 1'b1; end
          FN_SLT:  begin w_alu_op = ALU_SLT; w_reg_we = 1'b1; end
          FN_SLL:  begin w_alu_op = ALU_SLL; w_reg_we = 1'b1; end
          FN_SRL:  begin w_alu_op = ALU_SRL; w_reg_we = 1'b1; end
          FN_JR:   w_npc_sel = NPC_JREG;
          default: ;
        endcase
      end
      OP_ADDI: begin w_use_imm = 1'b1; w_reg_we = 1'b1; w_dst = DST_RT; end
      OP_ORI:  begin w_alu_op = ALU_OR; w_use_imm = 1'b1; w_imm_zx = 1'b1;
                     w_reg_we = 1'b1; w_dst = DST_RT; end
      OP_LUI:  begin w_alu_op = ALU_LUI; w_reg_we = 1'b1; w_dst = DST_RT; end
      OP_LW:   begin w_use_imm = 1'b1; w_reg_we = 1'b1; w_dst = DST_RT; w_mem_rd = 1'b1; end
      OP_SW:   begin w_use_imm = 1'b1; w_mem_we = 1'b1; end
      OP_BEQ:  w_npc_sel = NPC_BRANCH;
      OP_BNE:  begin w_npc_sel = NPC_BRANCH; w_br_ne = 1'b1; end
      OP_J:    w_npc_sel = NPC_JUMP;
      OP_JAL:  begin w_npc_sel = NPC_JUMP; w_reg_we = 1'b1; w_dst = DST_RA; end
      default: ;
    endcase
  end

  assign w_src_b = w_use_imm ? (w_imm_zx ? w_imm_zext : w_imm_sext) : w_rt_val;

  // ALU: add/sub wrap naturally at 32 bits; shifts take rt and shamt
  always_comb begin
    w_alu_y = '0;
    case (w_alu_op)
      ALU_ADD: w_alu_y = w_rs_val + w_src_b;
      ALU_SUB: w_alu_y = w_rs_val - w_src_b;
      ALU_AND: w_alu_y = w_rs_val & w_src_b;
      ALU_OR:  w_alu_y = w_rs_val | w_src_b;
      ALU_SLT: w_alu_y = {{(XLEN-1){1'b0}}, ($signed(w_rs_val) < $signed(w_src_b))};
      ALU_SLL: w_alu_y = w_rt_val << instr[10:6];
      ALU_SRL: w_alu_y = w_rt_val >> instr[10:6];
      ALU_LUI: w_alu_y = {instr[15:0], 16'h0000};
      default: w_alu_y = '0;
    endcase
  end

  assign dm_addr  = w_alu_y[8:2];
  assign dm_wdata = w_rt_val;
  assign dm_we    = w_mem_we;

  assign w_wa = (w_dst == DST_RA) ? 5'd31 :
                (w_dst == DST_RT) ? instr[20:16] : instr[15:11];
  assign w_wb_data = (w_dst == DST_RA) ? w_pc_plus4 :
                     w_mem_rd          ? dm_rdata   : w_alu_y;

  sc_rf U_RF (
    .clk      (clk),
    .rstn     (rstn),
    .ra1      (instr[25:21]),
    .ra2      (instr[20:16]),
    .rd1      (w_rs_val),
    .rd2      (w_rt_val),
    .we       (w_reg_we),
    .wa       (w_wa),
    .wd       (w_wb_data),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  assign w_pc_plus4 = PC + 32'd4;
  assign w_br_tgt   = w_pc_plus4 + {w_imm_sext[29:0], 2'b00};
  assign w_jmp_tgt  = {w_pc_plus4[31:28], instr[25:0], 2'b00};
  assign w_br_taken = (w_rs_val == w_rt_val) ^ w_br_ne;

  // Next-PC selection
  always_comb begin
    w_pc_next = w_pc_plus4;
    case (w_npc_sel)
      NPC_BRANCH: w_pc_next = w_br_taken ? w_br_tgt : w_pc_plus4;
      NPC_JUMP:   w_pc_next = w_jmp_tgt;
      NPC_JREG:   w_pc_next = w_rs_val;
      default:    w_pc_next = w_pc_plus4;
    endcase
  end

  // Program counter: one instruction retires per rising edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) PC <= '0;
    else       PC <= w_pc_next;
  end

endmodule : sc_cpu
`default_nettype wire

// File: rtl/sc_dm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sc_dm                                                  |
// | Description : 128-word data RAM, combinational read, write on edge,  |
// |               cleared by reset.                                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sc_dm
  import sc_comp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      rdata
);

  logic [XLEN-1:0] mem [0:DM_DEPTH-1];

  // Clear on reset, otherwise store one word per edge when enabled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DM_DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule : sc_dm
`default_nettype wire

// File: rtl/sc_im.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sc_im                                                  |
// | Description : 128-word instruction ROM, asynchronous word read.      |
// |               Contents are loaded externally into ROM[].             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sc_im
  import sc_comp_pkg::*;
(
  input  logic [ADDR_BITS-1:0] addr,
  output logic [XLEN-1:0]      data
);

  logic [XLEN-1:0] ROM [0:IM_DEPTH-1];

  assign data = ROM[addr];

endmodule : sc_im
`default_nettype wire

// File: rtl/sc_rf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sc_rf                                                  |
// | Description : 32x32 register file, two combinational read ports,    |
// |               one write port, rf[0] hard-wired to zero.              |
// |               Debug read port built only when SC_COMP_REGDBG_EN is   |
// |               defined; otherwise dbg_data is tied to zero.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sc_rf
  import sc_comp_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      dbg_sel,
  output logic [XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] rf [0:31];

  // Clear everything on reset; commit at most one write per edge, never to rf[0]
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      rf[wa] <= wd;
    end
  end

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

`ifdef SC_COMP_REGDBG_EN
  assign dbg_data = (dbg_sel == 5'd0) ? '0 : rf[dbg_sel];
`else
  logic w_unused_dbg_sel;
  assign w_unused_dbg_sel = ^dbg_sel;
  assign dbg_data         = '0;
`endif

endmodule : sc_rf
`default_nettype wire

// File: rtl/sc_comp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sc_comp                                                |
// | Description : Single-cycle MIPS-subset computer: CPU core, 128-word  |
// |               instruction ROM and 128-word data RAM.                 |
// |               SC_COMP_REGDBG_EN enables the reg_sel/reg_data debug   |
// |               read; without it reg_data is constant zero.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sc_comp
  import sc_comp_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);

  logic [XLEN-1:0]      PC;
  logic [XLEN-1:0]      instr;
  logic [ADDR_BITS-1:0] w_dm_addr;
  logic [XLEN-1:0]      w_dm_wdata, w_dm_rdata;
  logic                 w_dm_we;
  logic                 w_unused_pc;

  // Only the word-index bits of PC address the ROM
  assign w_unused_pc = ^{PC[31:9], PC[1:0]};

  sc_im U_IM (
    .addr (PC[8:2]),
    .data (instr)
  );

  sc_cpu U_SCPU (
    .clk      (clk),
    .rstn     (rstn),
    .instr    (instr),
    .PC       (PC),
    .dm_addr  (w_dm_addr),
    .dm_wdata (w_dm_wdata),
    .dm_we    (w_dm_we),
    .dm_rdata (w_dm_rdata),
    .dbg_sel  (reg_sel),
    .dbg_data (reg_data)
  );

  sc_dm U_DM (
    .clk   (clk),
    .rstn  (rstn),
    .we    (w_dm_we),
    .addr  (w_dm_addr),
    .wdata (w_dm_wdata),
    .rdata (w_dm_rdata)
  );

endmodule : sc_comp
`default_nettype wire

// File: tb/tb_sc_comp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sc_comp                                             |
// | Description : Directed program for sc_comp checked each cycle        |
// |               against an instruction-level model, plus fixed         |
// |               expected values at key points of the program.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_sc_comp;

  localparam logic [5:0] T_J = 6'h02, T_JAL = 6'h03, T_BEQ = 6'h04, T_BNE = 6'h05;
  localparam logic [5:0] T_ADDI = 6'h08, T_ORI = 6'h0D, T_LUI = 6'h0F, T_LW = 6'h23, T_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [4:0]  reg_sel = 5'd0;
  logic [31:0] reg_data;
  logic        run = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] prog [0:127];
  logic [31:0] m_rf [0:31];
  logic [31:0] m_dm [0:127];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  sc_comp dut (
    .clk      (clk),
    .rstn     (rstn),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // One comparison over the whole register file, against the model or against zero
  task automatic check_rf(input string name, input logic zero_only);
    int bad;
    logic [31:0] want;
    bad = -1;
    for (int i = 0; i < 32; i++) begin
      want = zero_only ? 32'h0 : m_rf[i];
      if (bad < 0 && dut.U_SCPU.U_RF.rf[i] !== want) bad = i;
    end
    n_vec++;
    if (bad >= 0) begin
      n_err++;
      want = zero_only ? 32'h0 : m_rf[bad];
      $display("FAIL %s: rf[%0d] got %08h expected %08h at %0t",
               name, bad, dut.U_SCPU.U_RF.rf[bad], want, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++)  m_rf[i] = 32'h0;
    for (int i = 0; i < 128; i++) m_dm[i] = 32'h0;
  endtask

  task automatic m_wr(input logic [4:0] idx, input logic [31:0] val);
    if (idx != 5'd0) m_rf[idx] = val;
  endtask

  // Architectural step: execute the instruction at m_pc on the bench's own copy of the program
  task automatic model_step();
    logic [31:0] ins, a, b, simm, ea, nxt;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    ins  = prog[m_pc[8:2]];
    op   = ins[31:26]; fn = ins[5:0];
    rs   = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
    a    = m_rf[rs];   b  = m_rf[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    ea   = a + simm;
    nxt  = m_pc + 32'd4;
    case (op)
      6'h00: case (fn)
        F_ADD: m_wr(rd, a + b);
        F_SUB: m_wr(rd, a - b);
        F_AND: m_wr(rd, a & b);
        F_OR:  m_wr(rd, a | b);
        F_SLT: m_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        F_SLL: m_wr(rd, b << sh);
        F_SRL: m_wr(rd, b >> sh);
        F_JR:  nxt = a;
        default: ;
      endcase
      T_ADDI: m_wr(rt, a + simm);
      T_ORI:  m_wr(rt, a | {16'h0, ins[15:0]});
      T_LUI:  m_wr(rt, {ins[15:0], 16'h0});
      T_LW:   m_wr(rt, m_dm[ea[8:2]]);
      T_SW:   m_dm[ea[8:2]] = b;
      T_BEQ:  if (a == b) nxt = m_pc + 32'd4 + (simm << 2);
      T_BNE:  if (a != b) nxt = m_pc + 32'd4 + (simm << 2);
      T_J:    nxt = {nxt[31:28], ins[25:0], 2'b00};
      T_JAL:  begin m_wr(5'd31, m_pc + 32'd4); nxt = {nxt[31:28], ins[25:0], 2'b00}; end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  function automatic logic [31:0] exp_dbg();
`ifdef SC_COMP_REGDBG_EN
    return (reg_sel == 5'd0) ? 32'h0 : m_rf[reg_sel];
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] lit_dbg(input logic [31:0] v);
`ifdef SC_COMP_REGDBG_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  // Per-cycle compare against the model, sampled 1 ns after each retiring edge
  always @(posedge clk) begin
    if (run) begin
      model_step();
      #1;
      check32("pc", dut.PC, m_pc);
      check32("pc_known", {31'd0, $isunknown(dut.PC)}, 32'd0);
      check_rf("rf", 1'b0);
      check32("reg_data", reg_data, exp_dbg());
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) prog[i] = 32'h0;
    prog[0]  = enc_i(T_ADDI, 5'd0, 5'd1, 16'd5);
    prog[1]  = enc_r(5'd0, 5'd1, 5'd2, 5'd3, F_SLL);
    prog[2]  = enc_r(5'd0, 5'd2, 5'd3, 5'd2, F_SRL);
    prog[3]  = enc_i(T_LUI, 5'd0, 5'd4, 16'h8000);
    prog[4]  = enc_r(5'd0, 5'd4, 5'd5, 5'd31, F_SRL);
    prog[5]  = enc_i(T_ADDI, 5'd0, 5'd6, 16'hFFFF);
    prog[6]  = enc_i(T_SW, 5'd0, 5'd2, 16'd4);
    prog[7]  = enc_i(T_LW, 5'd0, 5'd7, 16'd4);
    prog[8]  = enc_i(T_BEQ, 5'd1, 5'd1, 16'd2);
    prog[9]  = enc_i(T_ADDI, 5'd0, 5'd8, 16'h0011);
    prog[10] = enc_i(T_ADDI, 5'd0, 5'd9, 16'h0022);
    prog[11] = enc_i(T_BNE, 5'd1, 5'd1, 16'd5);
    prog[12] = enc_j(T_JAL, 26'h10);
    prog[13] = enc_i(T_ADDI, 5'd0, 5'd0, 16'd9);
    prog[14] = enc_j(T_J, 26'h12);
    prog[15] = enc_i(T_ADDI, 5'd0, 5'd10, 16'h0033);
    prog[16] = enc_r(5'd1, 5'd6, 5'd11, 5'd0, F_ADD);
    prog[17] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, F_JR);
    prog[18] = enc_r(5'd1, 5'd2, 5'd12, 5'd0, F_SUB);
    prog[19] = enc_r(5'd6, 5'd1, 5'd13, 5'd0, F_SLT);
    prog[20] = enc_r(5'd2, 5'd3, 5'd14, 5'd0, F_AND);
    prog[21] = enc_r(5'd2, 5'd3, 5'd15, 5'd0, F_OR);
    prog[22] = enc_i(T_ORI, 5'd0, 5'd16, 16'h8001);
    prog[23] = enc_i(T_SW, 5'd0, 5'd1, 16'd6);
    prog[24] = enc_i(T_LW, 5'd0, 5'd17, 16'd7);
    prog[25] = 32'hFC00_0000;
    prog[26] = enc_j(T_J, 26'h1A);

    #1 rstn = 1'b0;
    for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = prog[i];
    model_reset();
    #20;
    check32("rst_pc", dut.PC, 32'h0);
    check_rf("rst_rf", 1'b1);

    // Partial run, then reset in the middle of a cycle
    @(negedge clk); rstn = 1'b1; run = 1'b1;
    repeat (9) @(negedge clk);
    check32("beq_skip_pc_run1", dut.PC, 32'h0000_002C);
    run = 1'b0;
    @(posedge clk); #3; rstn = 1'b0; #1;
    check32("midrst_pc", dut.PC, 32'h0);
    check_rf("midrst_rf", 1'b1);
    #20;
    model_reset();

    // Full run from PC 0
    @(negedge clk); rstn = 1'b1; run = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      reg_sel = 5'(k * 5);
      case (k)
        3: begin
          check32("addi_r1", dut.U_SCPU.U_RF.rf[1], 32'h5);
          check32("sll_r2", dut.U_SCPU.U_RF.rf[2], 32'h28);
          check32("srl_r3", dut.U_SCPU.U_RF.rf[3], 32'hA);
        end
        9:  check32("beq_skip_pc", dut.PC, 32'h0000_002C);
        11: begin
          check32("jal_pc", dut.PC, 32'h0000_0040);
          check32("jal_r31", dut.U_SCPU.U_RF.rf[31], 32'h0000_0034);
        end
        13: check32("jr_pc", dut.PC, 32'h0000_0034);
        15: begin
          check32("j_pc", dut.PC, 32'h0000_0048);
          check32("lui_r4", dut.U_SCPU.U_RF.rf[4], 32'h8000_0000);
          check32("srl_zero_fill_r5", dut.U_SCPU.U_RF.rf[5], 32'h1);
          check32("addi_neg_r6", dut.U_SCPU.U_RF.rf[6], 32'hFFFF_FFFF);
          check32("lw_r7", dut.U_SCPU.U_RF.rf[7], 32'h28);
          check32("skipped_r8", dut.U_SCPU.U_RF.rf[8], 32'h0);
          check32("skipped_r9", dut.U_SCPU.U_RF.rf[9], 32'h0);
          check32("r0_zero", dut.U_SCPU.U_RF.rf[0], 32'h0);
          check32("add_r11", dut.U_SCPU.U_RF.rf[11], 32'h4);
          check32("j_skip_r10", dut.U_SCPU.U_RF.rf[10], 32'h0);
          reg_sel = 5'd7;
          #1;
          check32("dbg_r7", reg_data, lit_dbg(32'h28));
          reg_sel = 5'd0;
          #1;
          check32("dbg_r0", reg_data, 32'h0);
        end
        24: begin
          check32("sub_r12", dut.U_SCPU.U_RF.rf[12], 32'hFFFF_FFDD);
          check32("slt_r13", dut.U_SCPU.U_RF.rf[13], 32'h1);
          check32("and_r14", dut.U_SCPU.U_RF.rf[14], 32'h8);
          check32("or_r15", dut.U_SCPU.U_RF.rf[15], 32'h2A);
          check32("ori_r16", dut.U_SCPU.U_RF.rf[16], 32'h0000_8001);
          check32("lw_offs_r17", dut.U_SCPU.U_RF.rf[17], 32'h5);
          check32("loop_pc", dut.PC, 32'h0000_0068);
        end
        30: check32("loop_pc_hold", dut.PC, 32'h0000_0068);
        default: ;
      endcase
    end
    run = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sc_comp
`default_nettype wire
